mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles, legal range 1..7.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_req  input  1  fetch-stage read request.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have ports if_rdata (output, DATA_W, fetched instruction) and if_done (output, 1, one-cycle completion pulse).
REQ-009 SHALL have ports dm_req (input, 1), dm_we (input, 1), dm_addr (input, ADDR_W) and dm_wdata (input, DATA_W), forming the MEM-stage request.
REQ-010 SHALL have ports dm_rdata (output, DATA_W, load data) and dm_done (output, 1, one-cycle completion pulse).
REQ-011 SHALL have memory-side ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W).
REQ-012 SHALL have ports stall_pc (output, 1, freeze PC and IF/ID) and stall_pipe (output, 1, freeze all pipeline registers).

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and DONE; the path is IDLE->ACCESS->DONE->IDLE, and requests are sampled only in IDLE.
REQ-014 SHALL grant the DM requester when both requests are high in IDLE, unless starve_cnt==3, in which case IF is granted.
REQ-015 SHALL increment starve_cnt (2 bits, saturating) on each contested arbitration IF loses, and clear it whenever IF is granted.
REQ-016 SHALL latch the owner, address, we and wdata at the grant edge; requester input changes after that edge are ignored.
REQ-017 SHALL drive mem_en=1 (with mem_we=dm_we for DM and 0 for IF) for exactly the first ACCESS cycle, and mem_en=0 at all other times.
REQ-018 SHALL, for a read granted at edge E0, sample mem_rdata at edge E(1+MEM_LAT) into the owner's rdata register and assert the owner's done during cycle E(1+MEM_LAT)..E(2+MEM_LAT).
REQ-019 SHALL, for a write granted at E0, assert dm_done during cycle E1..E2; the memory captures the write at E1.
REQ-020 SHALL hold if_rdata and dm_rdata stable until the next completed read by the same owner.
REQ-021 SHALL complete an access whose req drops before done and still pulse done; the data is discarded by the requester.
REQ-022 SHALL keep a requester's req asserted until it sees done, then deassert it or present a new request in the next cycle.
REQ-023 SHALL compute stall_pc = (if_req & ~if_done) | stall_pipe and stall_pipe = dm_req & ~dm_done, both combinational.
REQ-024 SHALL implement a latency counter of 3 bits loaded with MEM_LAT on entry to ACCESS, decrementing to 0 with no wrap.

Reset
REQ-025 SHALL, while reset=0, immediately force state=IDLE, starve_cnt=0, counter=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, if_done=dm_done=0 and if_rdata=dm_rdata=0.
REQ-026 SHALL abandon an in-flight access when reset is asserted mid-ACCESS, pulse no done, and discard late mem_rdata.
REQ-027 SHALL return the first grant after reset release to DM if both requests are high.

Structure
REQ-028 SHALL take the FSM state encoding, the starve threshold (3) and the MEM_LAT default from shared package mem_arb_pkg.
REQ-029 SHALL place the latency counter in sub-module mem_lat_counter (load, decrement, zero flag).

Verification
REQ-030 SHALL cover an IF read only, MEM_LAT=2, if_addr=0x00400004, mem returning 0x8C080000: if_done is high exactly 3 cycles after the grant edge, and if_rdata=0x8C080000.
REQ-031 SHALL cover a DM write only, dm_addr=0x10010000, dm_wdata=0xDEADBEEF: one mem_en/mem_we cycle with those values, dm_done at E1, and stall_pipe low after dm_done.
REQ-032 SHALL cover if_req and dm_req held continuously: grants follow DM,DM,DM,IF, repeating, and the IF starve count never exceeds 3.
REQ-033 SHALL cover if_addr changed to 0x00400008 one cycle after grant: mem_addr stays 0x00400004.
REQ-034 SHALL cover reset pulsed low during ACCESS of a DM read: all outputs are 0 immediately, no dm_done, and the next access works normally.
REQ-035 SHALL cover MEM_LAT=1 versus 3: the read done edge moves to E2 and E4 respectively.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter: FSM encoding,
// requester identity, starvation threshold and default memory latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } owner_e;

  localparam logic [1:0]  StarveMax     = 2'd3;
  localparam int unsigned MemLatDefault = 2;
  localparam int unsigned LatCntW       = 3;

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency down-counter: loads a start value, counts down to zero and holds there.
module mem_lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between the fetch (IF) and data (DM) stages,
// favouring DM but forcing an IF grant after three consecutive contested losses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = MemLatDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pc,
  output logic              stall_pipe
);

  localparam logic [LatCntW-1:0] LatInit = LatCntW'(MEM_LAT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [1:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              mem_en_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              grant, capture, cnt_zero;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    grant    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      StIdle: begin
        if (if_req || dm_req) begin
          grant   = 1'b1;
          state_d = StAccess;
          if (dm_req && (!if_req || (starve_q != StarveMax))) begin
            owner_d = OwnDm;
            // Only a contested loss counts against IF.
            if (if_req) begin
              starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 2'd1;
            end
          end else begin
            owner_d  = OwnIf;
            starve_d = 2'd0;
          end
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d = StDone;
        end else if (cnt_zero) begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      starve_q   <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      mem_en_q <= grant;
      if (grant) begin
        if (owner_d == OwnDm) begin
          addr_q  <= dm_addr;
          wdata_q <= dm_wdata;
          we_q    <= dm_we;
        end else begin
          addr_q  <= if_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      end
      if (capture) begin
        if (owner_q == OwnDm) begin
          dm_rdata_q <= mem_rdata;
        end else begin
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  mem_lat_counter #(
    .W (LatCntW)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (LatInit),
    .dec      (state_q == StAccess),
    .zero     (cnt_zero)
  );

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_done  = (state_q == StDone) && (owner_q == OwnIf);
  assign dm_done  = (state_q == StDone) && (owner_q == OwnDm);

  assign stall_pipe = dm_req & ~dm_done;
  assign stall_pc   = (if_req & ~if_done) | stall_pipe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single reads/writes, starvation rotation,
// request changes after grant, mid-access reset, and latency variants 1/2/3.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, mem_en, mem_we, stall_pc, stall_pipe;

  logic [31:0] if_rdata_l1, dm_rdata_l1, mem_addr_l1, mem_wdata_l1;
  logic        if_done_l1, dm_done_l1, mem_en_l1, mem_we_l1, stall_pc_l1, stall_pipe_l1;
  logic [31:0] if_rdata_l3, dm_rdata_l3, mem_addr_l3, mem_wdata_l3;
  logic        if_done_l3, dm_done_l3, mem_en_l3, mem_we_l3, stall_pc_l3, stall_pipe_l3;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_pc(stall_pc), .stall_pipe(stall_pipe)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l1), .if_done(if_done_l1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_l1), .dm_done(dm_done_l1),
    .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1),
    .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata),
    .stall_pc(stall_pc_l1), .stall_pipe(stall_pipe_l1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l3), .if_done(if_done_l3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_l3), .dm_done(dm_done_l3),
    .mem_en(mem_en_l3), .mem_we(mem_we_l3), .mem_addr(mem_addr_l3),
    .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata),
    .stall_pc(stall_pc_l3), .stall_pipe(stall_pipe_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    if_addr   = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    #2;
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dones", {30'b0, if_done, dm_done}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_wdata, 32'd0);
    chk("rst_aux", {31'b0, |{if_rdata_l1, dm_rdata_l1, mem_addr_l1, mem_wdata_l1, if_done_l1,
        dm_done_l1, mem_en_l1, mem_we_l1, stall_pc_l1, stall_pipe_l1, if_rdata_l3,
        dm_rdata_l3, mem_addr_l3, mem_wdata_l3, if_done_l3, dm_done_l3, mem_en_l3,
        mem_we_l3, stall_pc_l3, stall_pipe_l3}}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // IF read, three latencies side by side; if_addr moves after grant
    mem_rdata = 32'h8C080000;
    if_addr   = 32'h00400004;
    if_req    = 1'b1;
    tick();  // E0
    chk("if_mem_en", {31'b0, mem_en}, 32'd1);
    chk("if_mem_we", {31'b0, mem_we}, 32'd0);
    chk("if_mem_addr", mem_addr, 32'h00400004);
    if_addr = 32'h00400008;
    tick();  // E1
    chk("if_e1_mem_en", {31'b0, mem_en}, 32'd0);
    chk("if_addr_latched", mem_addr, 32'h00400004);
    chk("if_e1_done", {31'b0, if_done}, 32'd0);
    tick();  // E2
    chk("if_e2_done", {31'b0, if_done}, 32'd0);
    chk("if_e2_stall_pc", {31'b0, stall_pc}, 32'd1);
    chk("lat1_done_e2", {31'b0, if_done_l1}, 32'd1);
    chk("lat1_rdata", if_rdata_l1, 32'h8C080000);
    tick();  // E3
    chk("if_e3_done", {31'b0, if_done}, 32'd1);
    chk("if_rdata", if_rdata, 32'h8C080000);
    chk("if_e3_stall_pc", {31'b0, stall_pc}, 32'd0);
    chk("lat1_done_e3", {31'b0, if_done_l1}, 32'd0);
    chk("lat3_done_e3", {31'b0, if_done_l3}, 32'd0);
    if_req    = 1'b0;
    mem_rdata = 32'h0BADF00D;
    tick();  // E4
    chk("if_e4_done", {31'b0, if_done}, 32'd0);
    chk("if_rdata_hold", if_rdata, 32'h8C080000);
    chk("lat3_done_e4", {31'b0, if_done_l3}, 32'd1);
    chk("lat3_rdata", if_rdata_l3, 32'h0BADF00D);
    repeat (2) tick();

    // DM write
    dm_addr  = 32'h10010000;
    dm_wdata = 32'hDEADBEEF;
    dm_we    = 1'b1;
    dm_req   = 1'b1;
    tick();  // E0
    chk("wr_mem_en", {31'b0, mem_en}, 32'd1);
    chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h10010000);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_stall_pipe", {31'b0, stall_pipe}, 32'd1);
    tick();  // E1
    chk("wr_done", {31'b0, dm_done}, 32'd1);
    chk("wr_e1_mem_en", {31'b0, mem_en}, 32'd0);
    chk("wr_stall_released", {30'b0, stall_pipe, stall_pc}, 32'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();  // E2
    chk("wr_e2_done", {31'b0, dm_done}, 32'd0);
    chk("wr_e2_stall_pipe", {31'b0, stall_pipe}, 32'd0);
    repeat (3) tick();

    // Both held: DM,DM,DM,IF repeating
    if_addr = 32'h00400010;
    dm_addr = 32'h10010004;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    for (int g = 0; g < 8; g++) begin
      int n;
      logic [31:0] exp_addr;
      exp_addr = ((g % 4) == 3) ? 32'h00400010 : 32'h10010004;
      n = 0;
      while (!mem_en && n < 12) begin
        tick();
        n++;
      end
      chk("rot_grant_seen", {31'b0, mem_en}, 32'd1);
      chk("rot_grant_owner", mem_addr, exp_addr);
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (6) tick();

    // Reset during a DM read
    mem_rdata = 32'hCAFEF00D;
    dm_addr   = 32'h10010008;
    dm_req    = 1'b1;
    tick();  // E0
    chk("rr_mem_en", {31'b0, mem_en}, 32'd1);
    tick();  // E1, mid-access
    reset = 1'b0;
    #1;
    chk("rr_mem_en_cleared", {31'b0, mem_en}, 32'd0);
    chk("rr_mem_addr_cleared", mem_addr, 32'd0);
    chk("rr_rdata_cleared", if_rdata | dm_rdata, 32'd0);
    chk("rr_done_cleared", {30'b0, if_done, dm_done}, 32'd0);
    dm_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rr_no_done_rst", {30'b0, if_done, dm_done}, 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_no_done_after", {31'b0, dm_done}, 32'd0);
      chk("rr_dm_rdata_zero", dm_rdata, 32'd0);
    end

    // First grant after reset with both requesting goes to DM
    mem_rdata = 32'h12345678;
    if_addr   = 32'h00400020;
    dm_addr   = 32'h1001000C;
    if_req    = 1'b1;
    dm_req    = 1'b1;
    tick();  // E0
    chk("post_rst_owner", mem_addr, 32'h1001000C);
    chk("post_rst_mem_en", {31'b0, mem_en}, 32'd1);
    repeat (2) tick();
    chk("post_rst_e2_done", {31'b0, dm_done}, 32'd0);
    tick();  // E3
    chk("post_rst_dm_done", {31'b0, dm_done}, 32'd1);
    chk("post_rst_dm_rdata", dm_rdata, 32'h12345678);
    chk("post_rst_if_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
